// File: rtl/sram_burst_master.sv
// Burst engine: turns burst commands plus a write stream into single-beat SRAM port accesses; returns read data as a stream.
// Latency: write beat hits SRAM in its handshake cycle; read data reaches rd_data 2 cycles after issue (FWFT FIFO); done 1 cycle after last beat/pop.
// Backpressure: wr_ready only in WRITE; read issue throttled so fifo_count + inflight never exceeds FIFO_DEPTH, so no read data is dropped.
module sram_burst_master #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 22,
   parameter int LEN_WIDTH  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  done,
   output logic                  busy,
   output logic                  sram_en,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_din,
   input  logic [DATA_WIDTH-1:0] sram_dout
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
   logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
   logic                  inflight_q, inflight_d;
   logic                  done_q, done_d;
   logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
   logic [DATA_WIDTH-1:0] din_hold_q, din_hold_d;
   logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]           count_q, count_d;
   logic                  push, pop, wr_issue, rd_issue, rd_room;

   // Read-return FIFO bookkeeping: the inflight beat is always pushed, head is shown directly
   always_comb begin
      push     = inflight_q;
      rd_valid = (count_q != '0);
      rd_data  = fifo_mem_q[rd_ptr_q];
      pop      = rd_valid && rd_ready;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
      // Room must cover both stored words and the read already on its way back
      rd_room  = (count_q + {{PW{1'b0}}, inflight_q}) < DEPTH_C;
   end

   // Burst FSM: next state, address/length stepping and handshakes
   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      inflight_d  = 1'b0;
      done_d      = 1'b0;
      cmd_ready   = 1'b0;
      wr_ready    = 1'b0;
      wr_issue    = 1'b0;
      rd_issue    = 1'b0;
      unique case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               cur_addr_d  = cmd_addr;
               remaining_d = cmd_len;
               if (cmd_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = cmd_write ? WRITE : READ;
               end
            end
         end
         WRITE: begin
            wr_ready = 1'b1;
            if (wr_valid) begin
               wr_issue    = 1'b1;
               cur_addr_d  = cur_addr_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == LEN_WIDTH'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         READ: begin
            if (rd_room) begin
               rd_issue    = 1'b1;
               inflight_d  = 1'b1;
               cur_addr_d  = cur_addr_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == LEN_WIDTH'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Finish in the cycle of the last pop so done follows it immediately
            if (!inflight_q && count_d == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // SRAM port drive: address/data follow the issue, otherwise hold their last value
   always_comb begin
      sram_en     = wr_issue || rd_issue;
      sram_we     = wr_issue;
      sram_addr   = sram_en ? cur_addr_q : addr_hold_q;
      sram_din    = wr_issue ? wr_data : din_hold_q;
      addr_hold_d = sram_addr;
      din_hold_d  = sram_din;
      busy        = (state_q != IDLE);
      done        = done_q;
   end

   // State registers; reset also discards any inflight read and FIFO contents
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         inflight_q  <= 1'b0;
         done_q      <= 1'b0;
         addr_hold_q <= '0;
         din_hold_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         inflight_q  <= inflight_d;
         done_q      <= done_d;
         addr_hold_q <= addr_hold_d;
         din_hold_q  <= din_hold_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // FIFO storage, written with the returning SRAM word
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= sram_dout;
      end
   end
endmodule

// File: tb/tb_sram_burst_master.sv
// Bench for sram_burst_master: directed bursts, expected accesses/data/done queued, negedge monitor compares.
// Latency: SRAM model returns zero-extended address one cycle after a read issue.
// Backpressure: rd_ready is driven per test to exercise FIFO throttling.
module tb_sram_burst_master;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [21:0] cmd_addr = '0;
   logic [15:0] cmd_len = '0;
   logic        wr_valid = 1'b0, wr_ready;
   logic [31:0] wr_data = '0;
   logic        rd_valid, rd_ready = 1'b1;
   logic [31:0] rd_data;
   logic        done, busy, sram_en, sram_we;
   logic [21:0] sram_addr;
   logic [31:0] sram_din;
   logic [31:0] sram_dout = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [21:0] q_wa[$];
   logic [31:0] q_wd[$];
   logic [21:0] q_ra[$];
   logic [31:0] q_rd[$];
   int          q_done[$];   // 0 = zero-length accept, 1 = last write, 2 = last pop

   int last_acc_cyc = -10, last_wr_cyc = -10, last_pop_cyc = -10;
   int run_len = 0, pop_run = 0, rd_issue_cnt = 0, done_cnt = 0;

   sram_burst_master dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .done(done), .busy(busy),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_din(sram_din), .sram_dout(sram_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (sram_en && !sram_we) sram_dout <= {10'b0, sram_addr};
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (cmd_valid && cmd_ready) last_acc_cyc = cyc;
         if (sram_en && sram_we) begin
            if (q_wa.size() == 0) chk("unexpected_write", 1, 0);
            else begin
               chk("wr_addr", sram_addr, q_wa.pop_front());
               chk("wr_data", sram_din, q_wd.pop_front());
            end
            run_len = (last_wr_cyc == cyc - 1) ? run_len + 1 : 1;
            last_wr_cyc = cyc;
         end
         if (sram_en && !sram_we) begin
            rd_issue_cnt++;
            if (q_ra.size() == 0) chk("unexpected_read_issue", 1, 0);
            else chk("rd_issue_addr", sram_addr, q_ra.pop_front());
         end
         if (rd_valid && rd_ready) begin
            if (q_rd.size() == 0) chk("unexpected_rd_data", 1, 0);
            else chk("rd_data", rd_data, q_rd.pop_front());
            pop_run = (last_pop_cyc == cyc - 1) ? pop_run + 1 : 1;
            last_pop_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            if (q_done.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               int k;
               int r;
               k = q_done.pop_front();
               r = (k == 0) ? last_acc_cyc : (k == 1) ? last_wr_cyc : last_pop_cyc;
               chk("done_timing", 64'(cyc), 64'(r + 1));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic w, input logic [21:0] a, input logic [15:0] l);
      int  t;
      logic hs;
      t = 0;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
      do begin
         hs = cmd_ready;
         step();
         t++;
      end while (!hs && t < 100);
      cmd_valid = 1'b0;
      if (!hs) chk("cmd_accept_timeout", 0, 1);
   endtask

   task automatic wait_done(input int base);
      int t;
      t = 0;
      while (done_cnt == base && t < 300) begin
         step();
         t++;
      end
      if (done_cnt == base) chk("done_timeout", 0, 1);
      else begin
         chk("busy_after_done", busy, 0);
         chk("cmd_ready_after_done", cmd_ready, 1);
      end
   endtask

   task automatic write_burst(input logic [21:0] a, input int n);
      int   i, t, base;
      logic hs;
      for (int k = 0; k < n; k++) begin
         q_wa.push_back(a + 22'(k));
         q_wd.push_back(32'hA0 + 32'(k));
      end
      q_done.push_back(1);
      base = done_cnt;
      send_cmd(1'b1, a, 16'(n));
      i = 0; t = 0;
      while (i < n && t < 200) begin
         wr_valid = 1'b1;
         wr_data  = 32'hA0 + 32'(i);
         hs = wr_ready;
         step();
         t++;
         if (hs) i++;
      end
      wr_valid = 1'b0;
      wait_done(base);
      chk("wr_consecutive", 64'(run_len), 64'(n));
   endtask

   task automatic queue_read(input logic [21:0] a, input int n);
      for (int k = 0; k < n; k++) begin
         q_ra.push_back(a + 22'(k));
         q_rd.push_back({10'b0, a + 22'(k)});
      end
   endtask

   initial begin
      int base, ibase, t;
      // Reset state
      repeat (3) step();
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_sram_en", sram_en, 0);
      chk("rst_sram_we", sram_we, 0);
      rst = 1'b0;
      step();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_wr_ready", wr_ready, 0);

      // Zero length, with stray write data offered that must be ignored
      wr_valid = 1'b1; wr_data = 32'hDEAD;
      q_done.push_back(0);
      base = done_cnt;
      send_cmd(1'b0, 22'h000040, 16'd0);
      chk("zero_cmd_ready", cmd_ready, 1);
      chk("zero_wr_ready", wr_ready, 0);
      chk("zero_done_pulse", done, 1);
      wr_valid = 1'b0;
      step();
      chk("zero_done_once", done_cnt, base + 1);

      // Write burst
      write_burst(22'h000100, 4);

      // Read burst at full rate
      rd_ready = 1'b1;
      queue_read(22'h000200, 8);
      q_done.push_back(2);
      base = done_cnt;
      send_cmd(1'b0, 22'h000200, 16'd8);
      wait_done(base);
      chk("rd_consecutive", 64'(pop_run), 8);

      // Read with backpressure
      rd_ready = 1'b0;
      queue_read(22'h000300, 8);
      q_done.push_back(2);
      base = done_cnt;
      ibase = rd_issue_cnt;
      send_cmd(1'b0, 22'h000300, 16'd8);
      repeat (20) step();
      chk("bp_issue_count", 64'(rd_issue_cnt - ibase), 4);
      chk("bp_rd_valid", rd_valid, 1);
      chk("bp_busy", busy, 1);
      rd_ready = 1'b1;
      wait_done(base);

      // Address wrap
      write_burst(22'h3FFFFE, 4);

      // Mid-burst reset during a read
      queue_read(22'h000400, 6);
      base = done_cnt;
      ibase = rd_issue_cnt;
      send_cmd(1'b0, 22'h000400, 16'd6);
      t = 0;
      while (rd_issue_cnt < ibase + 2 && t < 100) begin
         step();
         t++;
      end
      rst = 1'b1;
      step();
      chk("mr_done", done, 0);
      chk("mr_busy", busy, 0);
      chk("mr_rd_valid", rd_valid, 0);
      chk("mr_sram_en", sram_en, 0);
      chk("mr_sram_we", sram_we, 0);
      q_ra.delete();
      q_rd.delete();
      rst = 1'b0;
      step();
      chk("mr_cmd_ready", cmd_ready, 1);
      repeat (4) step();
      chk("mr_no_done", done_cnt, base);
      chk("mr_rd_valid_idle", rd_valid, 0);

      // New burst after reset
      queue_read(22'h000500, 3);
      q_done.push_back(2);
      base = done_cnt;
      send_cmd(1'b0, 22'h000500, 16'd3);
      wait_done(base);

      repeat (5) step();
      chk("end_q_wa", q_wa.size(), 0);
      chk("end_q_ra", q_ra.size(), 0);
      chk("end_q_rd", q_rd.size(), 0);
      chk("end_q_done", q_done.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
